pulse_param_bank: RTL and testbench

- Parametrised, multi-channel successor to the fixed-value pulse setup: holds NCH independent pulse-timing parameter sets that feed the `pulses` generators.
- Loads defaults on reset and accepts host register writes into shadow registers.
- Computes derived edges (p2start, sync_up, att_down) and range-checks them.
- Commits all channels atomically on the next period boundary, so a running sequence never sees a torn configuration.

---
 rtl/pulse_cfg_pkg.sv | 30 +++
 rtl/pulse_edge_calc.sv | 34 +++
 rtl/pulse_param_bank.sv | 248 ++++++++++++++++++++++++
 tb/tb_pulse_param_bank.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_cfg_pkg.sv
// Shared definitions for the pulse parameter bank: register map, FSM states,
// flag-word layout and reset defaults.
package pulse_cfg_pkg;

    localparam logic [2:0] REG_PERIOD  = 3'd0;
    localparam logic [2:0] REG_P1WIDTH = 3'd1;
    localparam logic [2:0] REG_P2WIDTH = 3'd2;
    localparam logic [2:0] REG_DELAY   = 3'd3;
    localparam logic [2:0] REG_ATTDLY  = 3'd4;
    localparam logic [2:0] REG_FLAGS   = 3'd5;

    localparam int FLAG_PUMP      = 0;
    localparam int FLAG_DOUBLE    = 1;
    localparam int FLAG_BLOCK_LSB = 8;
    localparam int FLAG_BLOCK_MSB = 15;

    localparam int unsigned DEFAULT_PERIOD = 20000;
    localparam int unsigned DEFAULT_P1W    = 30;
    localparam int unsigned DEFAULT_P2W    = 30;
    localparam int unsigned DEFAULT_DELAY  = 200;
    localparam int unsigned DEFAULT_ATTDLY = 2000;
    localparam int unsigned DEFAULT_BLOCK  = 50;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ARMED = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_edge_calc.sv
// Derived-edge adder chain for one channel, with overflow and range validation.
module pulse_edge_calc #(
    parameter int W = 32
) (
    input  logic [W-1:0] period,
    input  logic [W-1:0] p1width,
    input  logic [W-1:0] p2width,
    input  logic [W-1:0] delay,
    input  logic [W-1:0] att_delay,
    output logic [W-1:0] p2start,
    output logic [W-1:0] sync_up,
    output logic [W-1:0] att_down,
    output logic         ok
);

    logic [W:0] sum_p2s;
    logic [W:0] sum_sy;
    logic [W:0] sum_ad;

    // The extra top bit of each sum is the carry; any carry rejects the set.
    always_comb begin
        sum_p2s  = {1'b0, p1width} + {1'b0, delay};
        sum_sy   = {1'b0, sum_p2s[W-1:0]} + {1'b0, p2width};
        sum_ad   = {1'b0, sum_sy[W-1:0]} + {1'b0, att_delay};
        p2start  = sum_p2s[W-1:0];
        sync_up  = sum_sy[W-1:0];
        att_down = sum_ad[W-1:0];
        ok = !(sum_p2s[W] || sum_sy[W] || sum_ad[W])
             && (p1width != '0)
             && (period != '0)
             && (sum_ad[W-1:0] < period);
    end

endmodule

// File: rtl/pulse_param_bank.sv
// Multi-channel pulse timing bank: shadow registers, sequential per-channel
// validation, and an atomic shadow-to-active commit on a period boundary.
module pulse_param_bank
    import pulse_cfg_pkg::*;
#(
    parameter int          W          = 32,
    parameter int          NCH        = 2,
    parameter int unsigned DEF_PERIOD = DEFAULT_PERIOD,
    parameter int unsigned DEF_P1W    = DEFAULT_P1W,
    parameter int unsigned DEF_P2W    = DEFAULT_P2W,
    parameter int unsigned DEF_DELAY  = DEFAULT_DELAY,
    parameter int unsigned DEF_ATTDLY = DEFAULT_ATTDLY,
    parameter int unsigned DEF_BLOCK  = DEFAULT_BLOCK
) (
    input  logic                    clk_pll,
    input  logic                    resetn,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [$clog2(NCH)+2:0]  wr_addr,
    input  logic [W-1:0]            wr_data,
    input  logic                    commit_req,
    input  logic                    period_start,
    output logic                    busy,
    output logic                    cfg_update,
    output logic                    commit_err,
    output logic [$clog2(NCH)-1:0]  err_ch,
    output logic [NCH*W-1:0]        period,
    output logic [NCH*W-1:0]        p1width,
    output logic [NCH*W-1:0]        p2start,
    output logic [NCH*W-1:0]        sync_up,
    output logic [NCH*W-1:0]        att_down,
    output logic [NCH-1:0]          pump,
    output logic [NCH-1:0]          double,
    output logic [NCH*8-1:0]        pulse_block,
    output logic [1:0]              dbg_state
);

    localparam int CH_W   = $clog2(NCH);
    localparam int ADDR_W = CH_W + 3;

    localparam logic [W-1:0] D_PERIOD = W'(DEF_PERIOD);
    localparam logic [W-1:0] D_P1W    = W'(DEF_P1W);
    localparam logic [W-1:0] D_P2W    = W'(DEF_P2W);
    localparam logic [W-1:0] D_DELAY  = W'(DEF_DELAY);
    localparam logic [W-1:0] D_ATTDLY = W'(DEF_ATTDLY);
    localparam logic [W-1:0] D_P2S    = W'(DEF_P1W + DEF_DELAY);
    localparam logic [W-1:0] D_SY     = W'(DEF_P1W + DEF_DELAY + DEF_P2W);
    localparam logic [W-1:0] D_AD     = W'(DEF_P1W + DEF_DELAY + DEF_P2W + DEF_ATTDLY);
    localparam logic [7:0]   D_BLOCK  = 8'(DEF_BLOCK);

    state_t state_q, state_d;
    logic [CH_W-1:0] calc_ch;
    logic            calc_last;

    logic [W-1:0] sh_period [NCH];
    logic [W-1:0] sh_p1w    [NCH];
    logic [W-1:0] sh_p2w    [NCH];
    logic [W-1:0] sh_delay  [NCH];
    logic [W-1:0] sh_attdly [NCH];
    logic         sh_pump   [NCH];
    logic         sh_double [NCH];
    logic [7:0]   sh_block  [NCH];

    logic [W-1:0] st_period [NCH];
    logic [W-1:0] st_p1w    [NCH];
    logic [W-1:0] st_p2s    [NCH];
    logic [W-1:0] st_sy     [NCH];
    logic [W-1:0] st_ad     [NCH];
    logic         st_pump   [NCH];
    logic         st_double [NCH];
    logic [7:0]   st_block  [NCH];

    logic [W-1:0] ac_period [NCH];
    logic [W-1:0] ac_p1w    [NCH];
    logic [W-1:0] ac_p2s    [NCH];
    logic [W-1:0] ac_sy     [NCH];
    logic [W-1:0] ac_ad     [NCH];
    logic         ac_pump   [NCH];
    logic         ac_double [NCH];
    logic [7:0]   ac_block  [NCH];

    logic [W-1:0] calc_p2s, calc_sy, calc_ad;
    logic         calc_ok;

    logic [CH_W-1:0] wr_ch;
    logic [2:0]      wr_reg;
    logic [31:0]     wr_ch_ext;
    logic            wr_fire;

    // Write handshake: a beat transfers on a rising edge where wr_valid and
    // wr_ready are both high; wr_ready is high only in IDLE, so the shadow set
    // is frozen while a commit is being validated or is waiting to land.
    assign wr_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;
    assign calc_last = (calc_ch == CH_W'(NCH - 1));

    always_comb begin
        wr_ch     = wr_addr[ADDR_W-1:3];
        wr_reg    = wr_addr[2:0];
        wr_ch_ext = 32'(wr_ch);
        wr_fire   = wr_valid && wr_ready && (wr_ch_ext < 32'(NCH));
    end

    pulse_edge_calc #(.W(W)) u_edge_calc (
        .period   (sh_period[calc_ch]),
        .p1width  (sh_p1w[calc_ch]),
        .p2width  (sh_p2w[calc_ch]),
        .delay    (sh_delay[calc_ch]),
        .att_delay(sh_attdly[calc_ch]),
        .p2start  (calc_p2s),
        .sync_up  (calc_sy),
        .att_down (calc_ad),
        .ok       (calc_ok)
    );

    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (commit_req) state_d = CALC;
            CALC:    if (!calc_ok) state_d = IDLE;
                     else if (calc_last) state_d = ARMED;
            ARMED:   if (period_start) state_d = ARMED == ARMED ? IDLE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writes to unmapped registers (6, 7) fall through the case and are dropped.
    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) begin
                sh_period[i] <= D_PERIOD;
                sh_p1w[i]    <= D_P1W;
                sh_p2w[i]    <= D_P2W;
                sh_delay[i]  <= D_DELAY;
                sh_attdly[i] <= D_ATTDLY;
                sh_pump[i]   <= 1'b1;
                sh_double[i] <= 1'b1;
                sh_block[i]  <= D_BLOCK;
            end
        end else if (wr_fire) begin
            case (wr_reg)
                REG_PERIOD:  sh_period[wr_ch] <= wr_data;
                REG_P1WIDTH: sh_p1w[wr_ch]    <= wr_data;
                REG_P2WIDTH: sh_p2w[wr_ch]    <= wr_data;
                REG_DELAY:   sh_delay[wr_ch]  <= wr_data;
                REG_ATTDLY:  sh_attdly[wr_ch] <= wr_data;
                REG_FLAGS: begin
                    sh_pump[wr_ch]   <= wr_data[FLAG_PUMP];
                    sh_double[wr_ch] <= wr_data[FLAG_DOUBLE];
                    sh_block[wr_ch]  <= wr_data[FLAG_BLOCK_MSB:FLAG_BLOCK_LSB];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            calc_ch    <= '0;
            commit_err <= 1'b0;
            err_ch     <= '0;
            cfg_update <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                st_period[i] <= D_PERIOD;
                st_p1w[i]    <= D_P1W;
                st_p2s[i]    <= D_P2S;
                st_sy[i]     <= D_SY;
                st_ad[i]     <= D_AD;
                st_pump[i]   <= 1'b1;
                st_double[i] <= 1'b1;
                st_block[i]  <= D_BLOCK;
                ac_period[i] <= D_PERIOD;
                ac_p1w[i]    <= D_P1W;
                ac_p2s[i]    <= D_P2S;
                ac_sy[i]     <= D_SY;
                ac_ad[i]     <= D_AD;
                ac_pump[i]   <= 1'b1;
                ac_double[i] <= 1'b1;
                ac_block[i]  <= D_BLOCK;
            end
        end else begin
            cfg_update <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (commit_req) begin
                        calc_ch    <= '0;
                        commit_err <= 1'b0;
                    end
                end
                CALC: begin
                    if (!calc_ok) begin
                        commit_err <= 1'b1;
                        err_ch     <= calc_ch;
                    end else begin
                        st_period[calc_ch] <= sh_period[calc_ch];
                        st_p1w[calc_ch]    <= sh_p1w[calc_ch];
                        st_p2s[calc_ch]    <= calc_p2s;
                        st_sy[calc_ch]     <= calc_sy;
                        st_ad[calc_ch]     <= calc_ad;
                        st_pump[calc_ch]   <= sh_pump[calc_ch];
                        st_double[calc_ch] <= sh_double[calc_ch];
                        st_block[calc_ch]  <= sh_block[calc_ch];
                        if (!calc_last) calc_ch <= calc_ch + 1'b1;
                    end
                end
                ARMED: begin
                    if (period_start) begin
                        for (int i = 0; i < NCH; i++) begin
                            ac_period[i] <= st_period[i];
                            ac_p1w[i]    <= st_p1w[i];
                            ac_p2s[i]    <= st_p2s[i];
                            ac_sy[i]     <= st_sy[i];
                            ac_ad[i]     <= st_ad[i];
                            ac_pump[i]   <= st_pump[i];
                            ac_double[i] <= st_double[i];
                            ac_block[i]  <= st_block[i];
                        end
                        cfg_update <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            period[i*W +: W]     = ac_period[i];
            p1width[i*W +: W]    = ac_p1w[i];
            p2start[i*W +: W]    = ac_p2s[i];
            sync_up[i*W +: W]    = ac_sy[i];
            att_down[i*W +: W]   = ac_ad[i];
            pump[i]              = ac_pump[i];
            double[i]            = ac_double[i];
            pulse_block[i*8 +: 8] = ac_block[i];
        end
    end

endmodule

// File: tb/tb_pulse_param_bank.sv
// Directed and randomized checks of pulse_param_bank against a behavioural
// model of the shadow/active register sets.
module tb_pulse_param_bank;

    localparam int W      = 32;
    localparam int NCH    = 2;
    localparam int CH_W   = $clog2(NCH);
    localparam int ADDR_W = CH_W + 3;
    localparam longint unsigned LIM = 64'd1 << W;

    logic                clk_pll = 1'b0;
    logic                resetn;
    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [W-1:0]        wr_data;
    logic                commit_req;
    logic                period_start;
    logic                busy;
    logic                cfg_update;
    logic                commit_err;
    logic [CH_W-1:0]     err_ch;
    logic [NCH*W-1:0]    period, p1width, p2start, sync_up, att_down;
    logic [NCH-1:0]      pump, double;
    logic [NCH*8-1:0]    pulse_block;
    logic [1:0]          dbg_state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model: shadow registers as raw register words (index = register number),
    // plus the active and staged sets as plain per-channel values.
    logic [W-1:0] m_sh [NCH][6];
    logic [W-1:0] a_period [NCH], a_p1w [NCH], a_p2s [NCH], a_sy [NCH], a_ad [NCH];
    logic         a_pump [NCH], a_double [NCH];
    logic [7:0]   a_block [NCH];
    logic [W-1:0] s_period [NCH], s_p1w [NCH], s_p2s [NCH], s_sy [NCH], s_ad [NCH];
    logic         s_pump [NCH], s_double [NCH];
    logic [7:0]   s_block [NCH];
    logic         m_err;
    int           m_err_ch;
    int           fch;

    pulse_param_bank #(.W(W), .NCH(NCH)) dut (
        .clk_pll     (clk_pll),
        .resetn      (resetn),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit_req  (commit_req),
        .period_start(period_start),
        .busy        (busy),
        .cfg_update  (cfg_update),
        .commit_err  (commit_err),
        .err_ch      (err_ch),
        .period      (period),
        .p1width     (p1width),
        .p2start     (p2start),
        .sync_up     (sync_up),
        .att_down    (att_down),
        .pump        (pump),
        .double      (double),
        .pulse_block (pulse_block),
        .dbg_state   (dbg_state)
    );

    always #5 clk_pll = ~clk_pll;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_pll);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
        end
    endtask

    function automatic void m_reset();
        for (int c = 0; c < NCH; c++) begin
            m_sh[c][0] = 20000;
            m_sh[c][1] = 30;
            m_sh[c][2] = 30;
            m_sh[c][3] = 200;
            m_sh[c][4] = 2000;
            m_sh[c][5] = 32'h0000_3203;   // block=50, double=1, pump=1
            a_period[c] = 20000;
            a_p1w[c]    = 30;
            a_p2s[c]    = 230;
            a_sy[c]     = 260;
            a_ad[c]     = 2260;
            a_pump[c]   = 1'b1;
            a_double[c] = 1'b1;
            a_block[c]  = 8'd50;
        end
        m_err    = 1'b0;
        m_err_ch = 0;
    endfunction

    // Returns the first rejected channel, or -1 with the staged set filled in.
    function automatic int model_calc();
        for (int c = 0; c < NCH; c++) begin
            longint unsigned per = 64'(m_sh[c][0]);
            longint unsigned p1  = 64'(m_sh[c][1]);
            longint unsigned p2  = 64'(m_sh[c][2]);
            longint unsigned dl  = 64'(m_sh[c][3]);
            longint unsigned at  = 64'(m_sh[c][4]);
            longint unsigned e1  = p1 + dl;
            longint unsigned e2  = e1 + p2;
            longint unsigned e3  = e2 + at;
            logic [W-1:0]    fl  = m_sh[c][5];
            if (e1 >= LIM || e2 >= LIM || e3 >= LIM || p1 == 0 || per == 0 || e3 >= per)
                return c;
            s_period[c] = m_sh[c][0];
            s_p1w[c]    = m_sh[c][1];
            s_p2s[c]    = W'(e1);
            s_sy[c]     = W'(e2);
            s_ad[c]     = W'(e3);
            s_pump[c]   = fl[0];
            s_double[c] = fl[1];
            s_block[c]  = fl[15:8];
        end
        return -1;
    endfunction

    function automatic void apply_staging();
        for (int c = 0; c < NCH; c++) begin
            a_period[c] = s_period[c];
            a_p1w[c]    = s_p1w[c];
            a_p2s[c]    = s_p2s[c];
            a_sy[c]     = s_sy[c];
            a_ad[c]     = s_ad[c];
            a_pump[c]   = s_pump[c];
            a_double[c] = s_double[c];
            a_block[c]  = s_block[c];
        end
    endfunction

    task automatic check_active(input string tag);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s.period%0d", tag, c),   period[c*W +: W],     a_period[c]);
            chk($sformatf("%s.p1width%0d", tag, c),  p1width[c*W +: W],    a_p1w[c]);
            chk($sformatf("%s.p2start%0d", tag, c),  p2start[c*W +: W],    a_p2s[c]);
            chk($sformatf("%s.sync_up%0d", tag, c),  sync_up[c*W +: W],    a_sy[c]);
            chk($sformatf("%s.att_down%0d", tag, c), att_down[c*W +: W],   a_ad[c]);
            chk($sformatf("%s.pump%0d", tag, c),     pump[c],              a_pump[c]);
            chk($sformatf("%s.double%0d", tag, c),   double[c],            a_double[c]);
            chk($sformatf("%s.block%0d", tag, c),    pulse_block[c*8 +: 8], a_block[c]);
        end
        chk({tag, ".commit_err"}, commit_err, m_err);
        chk({tag, ".err_ch"}, err_ch, m_err_ch);
    endtask

    task automatic do_write(input int ch, input int rg, input logic [W-1:0] data);
        int waited = 0;
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(ch * 8 + rg);
        wr_data  = data;
        while (!wr_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!wr_ready) chk("write_ready_timeout", wr_ready, 1'b1);
        tick();
        wr_valid = 1'b0;
        if (rg <= 5) m_sh[ch][rg] = data;
    endtask

    task automatic fire_period();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        apply_staging();
        chk("cfg_update_pulse", cfg_update, 1'b1);
        chk("busy_after_update", busy, 1'b0);
        check_active("committed");
        tick();
        chk("cfg_update_single", cfg_update, 1'b0);
    endtask

    task automatic run_commit(input int wait_cycles, input bit fire);
        fch = model_calc();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        m_err = 1'b0;
        chk("busy_on_commit", busy, 1'b1);
        chk("err_cleared", commit_err, 1'b0);
        chk("ready_low_calc", wr_ready, 1'b0);
        for (int c = 0; c < NCH; c++) begin
            tick();
            if (fch == c) begin
                m_err    = 1'b1;
                m_err_ch = c;
                chk("busy_after_reject", busy, 1'b0);
                check_active("after_reject");
                return;
            end
            chk("busy_calc", busy, 1'b1);
            chk("no_update_calc", cfg_update, 1'b0);
        end
        for (int i = 0; i < wait_cycles; i++) begin
            tick();
            chk("busy_armed", busy, 1'b1);
            chk("no_update_armed", cfg_update, 1'b0);
        end
        check_active("armed_hold");
        if (fire) fire_period();
    endtask

    task automatic idle_period_start();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        chk("idle_ps_no_update", cfg_update, 1'b0);
    endtask

    initial begin
        resetn       = 1'b0;
        wr_valid     = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        commit_req   = 1'b0;
        period_start = 1'b0;
        m_reset();
        repeat (3) tick();
        check_active("in_reset");
        chk("reset_ready", wr_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_cfg_update", cfg_update, 1'b0);
        resetn = 1'b1;

        // Idle after reset: defaults hold, stray period_start does nothing.
        for (int i = 0; i < 10; i++) begin
            period_start = (i % 3 == 0);
            tick();
            chk("idle_cfg_update", cfg_update, 1'b0);
        end
        period_start = 1'b0;
        chk("def_att_down0", att_down[0 +: W], 2260);
        chk("def_p2start1", p2start[W +: W], 230);
        check_active("after_reset");

        // ch1 delay=400, commit, period_start 10 cycles later.
        do_write(1, 3, 400);
        run_commit(10, 1'b1);
        chk("ch1_p2start", p2start[W +: W], 430);
        chk("ch1_sync_up", sync_up[W +: W], 460);
        chk("ch1_att_down", att_down[W +: W], 2460);
        chk("ch0_unchanged", att_down[0 +: W], 2260);

        // att_down 20060 exceeds the period on ch0.
        do_write(0, 4, 19800);
        run_commit(0, 1'b1);
        chk("range_err", commit_err, 1'b1);
        chk("range_err_ch", err_ch, 0);
        do_write(0, 4, 2000);

        // att_down exactly equal to period is rejected.
        do_write(0, 4, 19740);
        run_commit(0, 1'b1);
        chk("equal_period_err", commit_err, 1'b1);
        do_write(0, 4, 19739);
        run_commit(2, 1'b1);
        chk("just_below_ok", att_down[0 +: W], 19999);
        do_write(0, 4, 2000);

        // Carry out of the first adder.
        do_write(0, 1, 32'hFFFF_FFF0);
        do_write(0, 3, 32'h20);
        run_commit(0, 1'b1);
        chk("carry_err", commit_err, 1'b1);
        do_write(0, 1, 30);
        do_write(0, 3, 200);

        // Zero p1width on the last channel.
        do_write(1, 1, 0);
        run_commit(0, 1'b1);
        chk("p1w_zero_err_ch", err_ch, 1);
        do_write(1, 1, 30);

        // Write to an unmapped register is dropped.
        do_write(0, 6, 32'h0000_0001);
        do_write(1, 7, 32'h0000_0000);
        run_commit(1, 1'b1);

        // period_start in the final CALC cycle is not used.
        do_write(0, 2, 45);
        fch = model_calc();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        for (int c = 0; c < NCH - 1; c++) tick();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        chk("late_ps_ignored", cfg_update, 1'b0);
        chk("late_ps_armed", busy, 1'b1);
        tick();
        chk("late_ps_still_armed", cfg_update, 1'b0);
        fire_period();
        chk("p2w45_sync_up0", sync_up[0 +: W], 275);

        // Write held off while ARMED; commit_req ignored there.
        do_write(1, 2, 40);
        run_commit(2, 1'b0);
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(0 * 8 + 0);
        wr_data  = 5000;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("armed_ready_low", wr_ready, 1'b0);
            chk("armed_busy", busy, 1'b1);
            tick();
        end
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        apply_staging();
        chk("held_update", cfg_update, 1'b1);
        chk("held_ready_back", wr_ready, 1'b1);
        check_active("held_commit");
        tick();
        wr_valid = 1'b0;
        m_sh[0][0] = 5000;
        chk("held_period_not_active", period[0 +: W], 20000);
        run_commit(1, 1'b1);
        chk("held_period_landed", period[0 +: W], 5000);

        // Reset while ARMED abandons the pending commit.
        do_write(1, 3, 400);
        do_write(0, 3, 400);
        run_commit(1, 1'b0);
        resetn = 1'b0;
        #2;
        m_reset();
        check_active("reset_armed");
        chk("reset_armed_busy", busy, 1'b0);
        tick();
        tick();
        resetn = 1'b1;
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("reset_no_update", cfg_update, 1'b0);
            tick();
        end
        check_active("reset_defaults");

        // Randomized writes and commits.
        for (int it = 0; it < 40; it++) begin
            int nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                int ch = $urandom_range(0, NCH - 1);
                int rg = $urandom_range(0, 7);
                logic [W-1:0] d;
                case (rg)
                    0: d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1000, 30000);
                    1: begin
                        int r = $urandom_range(0, 9);
                        d = (r == 0) ? 0 : (r == 1) ? (32'hFFFF_F000 | $urandom_range(0, 4095))
                                                     : $urandom_range(1, 100);
                    end
                    2: d = $urandom_range(0, 100);
                    3: d = $urandom_range(0, 3000);
                    4: d = $urandom_range(0, 20000);
                    default: d = $urandom;
                endcase
                do_write(ch, rg, d);
            end
            if ($urandom_range(0, 3) == 0) idle_period_start();
            run_commit($urandom_range(0, 5), 1'b1);
        end
        check_active("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
